console_out_arbiter: RTL and testbench

Shares the single console output channel (`CONSOLE_OUT` / `CONSOLE_OUT_valid` / `CONSOLE_OUT_ready` at the Wrapper boundary) between two byte producers: the CPU memory-mapped console port (requester 0) and the debug/monitor path (requester 1). Messages are arbitrated round-robin and are never interleaved, because a grant is held until the owner's last byte. Accepted bytes are buffered in a small FIFO that drains to the console under a valid/ready handshake. The block sits inside Wrapper, between the two producers and the top-level console output ports.

---
 rtl/console_out_arbiter_pkg.sv | 13 +
 rtl/console_out_arbiter_fifo.sv | 56 +++++
 rtl/console_out_arbiter.sv | 87 ++++++++
 tb/tb_console_out_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/console_out_arbiter_pkg.sv
// Shared definitions for the console output arbiter: default byte width and
// arbiter state encoding.
package console_out_arbiter_pkg;

   localparam int unsigned CONSOLE_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/console_out_arbiter_fifo.sv
// Small synchronous FIFO feeding the console; storage is not reset and the
// head output is masked to zero while empty.
module console_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/console_out_arbiter.sv
// Round-robin arbiter sharing the console output between the CPU console port
// (requester 0) and the debug path (requester 1); grants are held per message.
module console_out_arbiter
   import console_out_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = CONSOLE_DATA_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [DATA_W-1:0]        REQ0_DATA,
   input  logic                     REQ0_VALID,
   input  logic                     REQ0_LAST,
   output logic                     REQ0_READY,
   input  logic [DATA_W-1:0]        REQ1_DATA,
   input  logic                     REQ1_VALID,
   input  logic                     REQ1_LAST,
   output logic                     REQ1_READY,
   output logic [DATA_W-1:0]        CONSOLE_OUT,
   output logic                     CONSOLE_OUT_valid,
   input  logic                     CONSOLE_OUT_ready,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

   arb_state_t        state;
   logic              prio;
   logic              grant0;
   logic              grant1;
   logic              acc0;
   logic              acc1;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] push_data;

   // IDLE arbitrates and accepts in the same cycle, so back-to-back messages
   // need no bubble.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      unique case (state)
         IDLE: begin
            grant0 = REQ0_VALID && (!REQ1_VALID || !prio);
            grant1 = REQ1_VALID && (!REQ0_VALID ||  prio);
         end
         OWN0:    grant0 = 1'b1;
         OWN1:    grant1 = 1'b1;
         default: ;
      endcase
   end

   assign REQ0_READY = grant0 && !fifo_full;
   assign REQ1_READY = grant1 && !fifo_full;
   assign acc0       = REQ0_VALID && REQ0_READY;
   assign acc1       = REQ1_VALID && REQ1_READY;
   assign push_data  = acc1 ? REQ1_DATA : REQ0_DATA;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else if (acc0) begin
         state <= REQ0_LAST ? IDLE : OWN0;
         if (REQ0_LAST) prio <= 1'b1;
      end else if (acc1) begin
         state <= REQ1_LAST ? IDLE : OWN1;
         if (REQ1_LAST) prio <= 1'b0;
      end
   end

   console_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET),
      .push      (acc0 || acc1),
      .push_data (push_data),
      .pop       (CONSOLE_OUT_ready),
      .pop_data  (CONSOLE_OUT),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (FIFO_COUNT)
   );

   assign CONSOLE_OUT_valid = !fifo_empty;

endmodule

// File: tb/tb_console_out_arbiter.sv
// Directed self-checking bench for console_out_arbiter (DATA_W=8, DEPTH=4).
module tb_console_out_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] REQ0_DATA;
   logic       REQ0_VALID;
   logic       REQ0_LAST;
   logic       REQ0_READY;
   logic [7:0] REQ1_DATA;
   logic       REQ1_VALID;
   logic       REQ1_LAST;
   logic       REQ1_READY;
   logic [7:0] CONSOLE_OUT;
   logic       CONSOLE_OUT_valid;
   logic       CONSOLE_OUT_ready;
   logic [2:0] FIFO_COUNT;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   console_out_arbiter #(
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .REQ0_DATA         (REQ0_DATA),
      .REQ0_VALID        (REQ0_VALID),
      .REQ0_LAST         (REQ0_LAST),
      .REQ0_READY        (REQ0_READY),
      .REQ1_DATA         (REQ1_DATA),
      .REQ1_VALID        (REQ1_VALID),
      .REQ1_LAST         (REQ1_LAST),
      .REQ1_READY        (REQ1_READY),
      .CONSOLE_OUT       (CONSOLE_OUT),
      .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
      .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
      .FIFO_COUNT        (FIFO_COUNT)
   );

   task automatic drive_idle();
      REQ0_VALID = 1'b0; REQ0_DATA = '0; REQ0_LAST = 1'b0;
      REQ1_VALID = 1'b0; REQ1_DATA = '0; REQ1_LAST = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RESET = 1'b0;
      drive_idle();
      step();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      CONSOLE_OUT_ready = 1'b0;
      drive_idle();
      repeat (2) step();
      vectors++; if (CONSOLE_OUT_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", CONSOLE_OUT_valid); end
      vectors++; if (CONSOLE_OUT !== 8'h00) begin miscompares++; $display("FAIL reset_out: got %h expected 00", CONSOLE_OUT); end
      vectors++; if (FIFO_COUNT !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", FIFO_COUNT); end
      vectors++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b%b expected 00", REQ0_READY, REQ1_READY); end
      RESET = 1'b1;
      step();
      vectors++; if (FIFO_COUNT !== 3'd0 || CONSOLE_OUT_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: got count %0d valid %b expected 0 0", FIFO_COUNT, CONSOLE_OUT_valid); end
   endtask

   task automatic test_single_msg();
      CONSOLE_OUT_ready = 1'b1;
      REQ0_VALID = 1'b1; REQ0_DATA = 8'h48; REQ0_LAST = 1'b0;
      #3;
      vectors++; if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin miscompares++; $display("FAIL single_grant: got %b%b expected 10", REQ0_READY, REQ1_READY); end
      step();
      vectors++; if (CONSOLE_OUT !== 8'h48 || CONSOLE_OUT_valid !== 1'b1) begin miscompares++; $display("FAIL single_byte0: got %h/%b expected 48/1", CONSOLE_OUT, CONSOLE_OUT_valid); end
      vectors++; if (FIFO_COUNT !== 3'd1) begin miscompares++; $display("FAIL single_count0: got %0d expected 1", FIFO_COUNT); end
      REQ0_DATA = 8'h49; REQ0_LAST = 1'b1;
      #3;
      vectors++; if (REQ0_READY !== 1'b1) begin miscompares++; $display("FAIL single_ready1: got %b expected 1", REQ0_READY); end
      step();
      vectors++; if (CONSOLE_OUT !== 8'h49 || FIFO_COUNT !== 3'd1) begin miscompares++; $display("FAIL single_byte1: got %h count %0d expected 49 count 1", CONSOLE_OUT, FIFO_COUNT); end
      drive_idle();
      step();
      vectors++; if (CONSOLE_OUT_valid !== 1'b0 || FIFO_COUNT !== 3'd0) begin miscompares++; $display("FAIL single_drained: got %b count %0d expected 0 count 0", CONSOLE_OUT_valid, FIFO_COUNT); end
      // prio is now 1: requester 1 wins a tie
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
      #3;
      vectors++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b1) begin miscompares++; $display("FAIL prio_flip: got %b%b expected 01", REQ0_READY, REQ1_READY); end
      drive_idle();
      step();
   endtask

   task automatic test_reset_mid();
      CONSOLE_OUT_ready = 1'b0;
      REQ1_VALID = 1'b1; REQ1_DATA = 8'h51; REQ1_LAST = 1'b0;
      step();
      REQ1_DATA = 8'h52;
      step();
      vectors++; if (FIFO_COUNT !== 3'd2) begin miscompares++; $display("FAIL mid_count: got %0d expected 2", FIFO_COUNT); end
      RESET = 1'b0;
      drive_idle();
      repeat (2) step();
      vectors++; if (FIFO_COUNT !== 3'd0 || CONSOLE_OUT_valid !== 1'b0 || CONSOLE_OUT !== 8'h00) begin miscompares++; $display("FAIL mid_reset: got count %0d valid %b out %h expected 0 0 00", FIFO_COUNT, CONSOLE_OUT_valid, CONSOLE_OUT); end
      RESET = 1'b1;
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
      #3;
      vectors++; if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin miscompares++; $display("FAIL mid_prio_reset: got %b%b expected 10", REQ0_READY, REQ1_READY); end
      drive_idle();
      step();
   endtask

   task automatic test_both();
      logic [7:0] d0  [3] = '{8'h41, 8'h42, 8'h43};
      logic [7:0] d1  [3] = '{8'h61, 8'h62, 8'h63};
      logic [7:0] exp [6] = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
      int i0 = 0, i1 = 0, k = 0;
      logic r0, r1;
      CONSOLE_OUT_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && k < 6; cyc++) begin
         REQ0_VALID = (i0 < 3); REQ0_DATA = (i0 < 3) ? d0[i0] : 8'h00; REQ0_LAST = (i0 == 2);
         REQ1_VALID = (i1 < 3); REQ1_DATA = (i1 < 3) ? d1[i1] : 8'h00; REQ1_LAST = (i1 == 2);
         #3;
         r0 = REQ0_READY; r1 = REQ1_READY;
         if (i0 < 3) begin
            vectors++; if (r1 !== 1'b0) begin miscompares++; $display("FAIL both_req1_blocked: got %b expected 0 (i0=%0d)", r1, i0); end
         end
         if (CONSOLE_OUT_valid) begin
            vectors++; if (CONSOLE_OUT !== exp[k]) begin miscompares++; $display("FAIL both_order[%0d]: got %h expected %h", k, CONSOLE_OUT, exp[k]); end
            k++;
         end
         step();
         if (r0 && REQ0_VALID) i0++;
         if (r1 && REQ1_VALID) i1++;
      end
      vectors++; if (k != 6) begin miscompares++; $display("FAIL both_timeout: got %0d bytes expected 6", k); end
      drive_idle();
   endtask

   task automatic test_full();
      logic [7:0] exp [6] = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
      int i1 = 0, k = 0;
      logic r1;
      logic first;
      apply_reset();
      CONSOLE_OUT_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         REQ1_VALID = (i1 < 6); REQ1_DATA = (i1 < 6) ? exp[i1] : 8'h00; REQ1_LAST = (i1 == 5);
         #3;
         r1 = REQ1_READY;
         step();
         if (r1 && REQ1_VALID) i1++;
      end
      vectors++; if (i1 != 4 || FIFO_COUNT !== 3'd4) begin miscompares++; $display("FAIL full_fill: got %0d accepts count %0d expected 4 count 4", i1, FIFO_COUNT); end
      REQ1_DATA = exp[i1]; REQ1_LAST = 1'b0;
      CONSOLE_OUT_ready = 1'b1;
      #3;
      vectors++; if (REQ1_READY !== 1'b0) begin miscompares++; $display("FAIL full_no_push_on_pop: got %b expected 0", REQ1_READY); end
      vectors++; if (CONSOLE_OUT !== exp[0]) begin miscompares++; $display("FAIL full_head: got %h expected %h", CONSOLE_OUT, exp[0]); end
      k = 1;
      step();
      vectors++; if (FIFO_COUNT !== 3'd3) begin miscompares++; $display("FAIL full_pop_count: got %0d expected 3", FIFO_COUNT); end
      first = 1'b1;
      for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
         REQ1_VALID = (i1 < 6); REQ1_DATA = (i1 < 6) ? exp[i1] : 8'h00; REQ1_LAST = (i1 == 5);
         #3;
         r1 = REQ1_READY;
         if (first) begin
            vectors++; if (r1 !== 1'b1) begin miscompares++; $display("FAIL full_push_resumes: got %b expected 1", r1); end
            first = 1'b0;
         end
         if (CONSOLE_OUT_valid) begin
            vectors++; if (CONSOLE_OUT !== exp[k]) begin miscompares++; $display("FAIL full_drain[%0d]: got %h expected %h", k, CONSOLE_OUT, exp[k]); end
            k++;
         end
         step();
         if (r1 && REQ1_VALID) i1++;
      end
      vectors++; if (k != 6 || FIFO_COUNT !== 3'd0) begin miscompares++; $display("FAIL full_drain_end: got %0d bytes count %0d expected 6 count 0", k, FIFO_COUNT); end
      drive_idle();
   endtask

   task automatic test_alternate();
      logic [7:0] exp [8] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
      logic [7:0] d0  [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      logic [7:0] d1  [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      int i0 = 0, i1 = 0, k = 0;
      logic r0, r1;
      apply_reset();
      CONSOLE_OUT_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && k < 8; cyc++) begin
         REQ0_VALID = (i0 < 4); REQ0_DATA = (i0 < 4) ? d0[i0] : 8'h00; REQ0_LAST = 1'b1;
         REQ1_VALID = (i1 < 4); REQ1_DATA = (i1 < 4) ? d1[i1] : 8'h00; REQ1_LAST = 1'b1;
         #3;
         r0 = REQ0_READY; r1 = REQ1_READY;
         if (CONSOLE_OUT_valid) begin
            vectors++; if (CONSOLE_OUT !== exp[k]) begin miscompares++; $display("FAIL alt_order[%0d]: got %h expected %h", k, CONSOLE_OUT, exp[k]); end
            k++;
         end
         step();
         if (r0 && REQ0_VALID) i0++;
         if (r1 && REQ1_VALID) i1++;
      end
      vectors++; if (k != 8) begin miscompares++; $display("FAIL alt_timeout: got %0d bytes expected 8", k); end
      drive_idle();
   endtask

   initial begin
      RESET = 1'b0;
      CONSOLE_OUT_ready = 1'b0;
      drive_idle();
      #1;
      test_reset();
      test_single_msg();
      test_reset_mid();
      test_both();
      test_full();
      test_alternate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
